// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between execute and a word-aligned data
// memory port. Accepts one request per handshake, places store data into byte
// lanes, extracts and extends load data, and reports errors.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake (req_ready is combinational)
//   req_is_store      1 = store, 0 = load
//   req_funct3        RV load/store funct3 encoding
//   req_addr          byte address
//   req_wdata         right-justified store data
//   mem_addr          word-aligned address
//   mem_read/write    access strobes, held for the whole access
//   mem_wmask/wdata   store byte enables and lane-shifted data
//   mem_rdata/resp    memory read data and completion
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata         extended load data (0 for stores and errors)
//   rsp_err           00 ok, 01 misaligned, 10 illegal funct3, 11 timeout
module mem_access_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [XLEN/8-1:0] mem_wmask,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_resp,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [1:0]        rsp_err
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned CNTW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit          IS64 = (XLEN == 64);

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FUNCT3   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              is_store_q, is_store_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [NB-1:0]     mem_wmask_q, mem_wmask_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_err_q, rsp_err_d;

  logic              accept;
  logic [OFFW-1:0]   req_off;
  logic              req_illegal;
  logic              req_misaligned;
  logic [2:0]        align_m;
  logic [NB-1:0]     size_mask;
  logic [XLEN-1:0]   load_shifted;
  logic [XLEN-1:0]   load_mask;
  logic              load_sbit;
  logic [XLEN-1:0]   load_ext;
  logic              timeout_hit;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign req_off   = req_addr[OFFW-1:0];

  // Request legality, alignment and store byte-mask decode.
  always_comb begin : req_decode
    req_illegal = 1'b0;
    if (req_is_store) begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
        3'b011:                 req_illegal = !IS64;
        default:                req_illegal = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_illegal = 1'b0;
        3'b011, 3'b110:                         req_illegal = !IS64;
        default:                                req_illegal = 1'b1;
      endcase
    end
    case (req_funct3[1:0])
      2'b00:   begin align_m = 3'd0; size_mask = NB'(8'h01); end
      2'b01:   begin align_m = 3'd1; size_mask = NB'(8'h03); end
      2'b10:   begin align_m = 3'd3; size_mask = NB'(8'h0F); end
      default: begin align_m = 3'd7; size_mask = NB'(8'hFF); end
    endcase
    req_misaligned = (req_off & OFFW'(align_m)) != '0;
  end

  // Load lane extraction; funct3[2] selects zero extension, ld passes through.
  always_comb begin : load_extract
    load_shifted = mem_rdata >> {off_q, 3'b000};
    case (funct3_q[1:0])
      2'b00:   begin load_mask = XLEN'(8'hFF);         load_sbit = load_shifted[7];  end
      2'b01:   begin load_mask = XLEN'(16'hFFFF);      load_sbit = load_shifted[15]; end
      2'b10:   begin load_mask = XLEN'(32'hFFFF_FFFF); load_sbit = load_shifted[31]; end
      default: begin load_mask = '1;                   load_sbit = 1'b0;             end
    endcase
    load_ext = load_shifted & load_mask;
    if (!funct3_q[2] && load_sbit) begin
      load_ext = load_ext | ~load_mask;
    end
  end

  // A response in the same cycle takes precedence over the timeout.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNTW'(TIMEOUT - 1));

  // Next-state and registered-output logic.
  always_comb begin : fsm_next
    state_d     = state_q;
    off_d       = off_q;
    funct3_d    = funct3_q;
    is_store_d  = is_store_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_wmask_d = mem_wmask_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          off_d      = req_off;
          funct3_d   = req_funct3;
          is_store_d = req_is_store;
          cnt_d      = '0;
          mem_addr_d = {req_addr[XLEN-1:OFFW], OFFW'(0)};
          if (req_illegal || req_misaligned) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = req_illegal ? ERR_FUNCT3 : ERR_MISALIGN;
            mem_wmask_d = '0;
            mem_wdata_d = '0;
          end else begin
            state_d     = ACCESS;
            mem_read_d  = !req_is_store;
            mem_write_d = req_is_store;
            mem_wmask_d = req_is_store ? (size_mask << req_off) : '0;
            mem_wdata_d = req_is_store ? (req_wdata << {req_off, 3'b000}) : '0;
          end
        end
      end
      ACCESS: begin
        if (mem_resp || timeout_hit) begin
          state_d     = DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          mem_wmask_d = '0;
          rsp_valid_d = 1'b1;
          if (mem_resp) begin
            rsp_err_d   = ERR_OK;
            rsp_rdata_d = is_store_q ? '0 : load_ext;
          end else begin
            rsp_err_d   = ERR_TIMEOUT;
            rsp_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      off_q       <= '0;
      funct3_q    <= '0;
      is_store_q  <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_wmask_q <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      funct3_q    <= funct3_d;
      is_store_q  <= is_store_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised load/store unit for the RV32I/RV64I datapath. It sits between the execute stage and the data memory port. It accepts one load or store per handshake and drives an XLEN-wide, word-aligned memory port with byte masks. It sign- or zero-extends load data per funct3 encoding and reports alignment, encoding and timeout errors.

## Interface
Parameters:
- XLEN, 32: datapath and memory port width. Legal values are 32 and 64.
- TIMEOUT, 0: maximum ACCESS cycles without mem_resp before a timeout error. 0 disables the timeout.

Clock and reset: one clock; reset is synchronous and active-high (`clk`, `rst`).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  load_funct3_t / store_funct3_t encoding; 011 = ld/sd, 110 = lwu (XLEN=64 only)
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-justified
- mem_addr  out  XLEN  req_addr with the low log2(XLEN/8) bits cleared
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- mem_wmask  out  XLEN/8  byte enables
- mem_wdata  out  XLEN  lane-shifted store data
- mem_rdata  in  XLEN  read data, valid with mem_resp
- mem_resp  in  1  memory completion
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
- rsp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout

## Operation
- FSM states: IDLE, ACCESS, DONE.
- req_ready = (state==IDLE) && !rst. This is combinational.
- Accept condition: req_valid && req_ready. On accept, latch addr, funct3, is_store, wdata and byte offset off = addr[log2(XLEN/8)-1:0].
- Checks on accept, in priority order:
  - illegal funct3 → err 10. Illegal means: loads other than 000/001/010/100/101, plus 011/110 when XLEN=64; stores other than 000/001/010, plus 011 when XLEN=64.
  - misaligned → err 01. Misaligned means: half with off[0]≠0, word with off[1:0]≠0, double with off[2:0]≠0.
- Error path: IDLE→DONE. mem_read and mem_write are never asserted.
- Legal path: IDLE→ACCESS. The registered mem_read or mem_write is held high for the whole ACCESS state.
- Store lane placement:
  - mem_wmask = size_mask << off, where size_mask = 1, 3, 0xF or 0xFF.
  - mem_wdata = req_wdata << (8*off).
  - For loads, mem_wmask = 0.
- Load extraction: shifted = mem_rdata >> (8*off), truncated to the access size. Extension by funct3:
  - lb, lh, lw: sign-extend.
  - lbu, lhu, lwu: zero-extend.
  - ld: no extension.
- ACCESS→DONE when mem_resp=1. Load data and err 00 are registered on that edge.
- Timeout: cnt clears on entry to ACCESS and increments each ACCESS cycle without mem_resp. If TIMEOUT>0 and cnt reaches TIMEOUT-1 with no response, ACCESS→DONE with err 11.
- If mem_resp arrives in the same cycle as the timeout condition, mem_resp wins and err is 00.
- DONE: rsp_valid=1 for exactly one cycle, then →IDLE. rsp_rdata and rsp_err are valid only while rsp_valid=1 and are held otherwise.
- mem_resp is ignored in IDLE and DONE.

## Timing
- Reset values: state IDLE, every output 0 (req_ready 0 while rst=1), cnt 0.
- Reset while in ACCESS: strobes are 0 in the cycle after the rst edge, no rsp_valid is produced, and the in-flight access is abandoned.
- Legal access latency:
  - Accept at edge E0; strobes high from E0 through the edge that samples mem_resp (Ek, k≥1).
  - Strobes low after Ek; rsp_valid high in cycle k+1.
  - Minimum is 2 cycles from accept to rsp_valid.
- Error latency: rsp_valid in the cycle after accept (1 cycle).
- Timeout: with no mem_resp, rsp_valid is asserted TIMEOUT+1 cycles after accept.
- Back-to-back requests: a new request is accepted in the cycle after rsp_valid, i.e. the first IDLE cycle. The unit holds at most one request in flight.
- All mem_* outputs and rsp_* outputs are registered.

## Test plan
- XLEN=32, lb at 0x1003, mem_rdata=0x80FF1234, resp after 1 cycle → mem_addr 0x1000, rsp_rdata 0xFFFFFF80, err 00, rsp_valid 2 cycles after accept. The same access as lbu → 0x00000080.
- sh at 0x2002, wdata 0x0000BEEF, resp after 3 cycles → mem_addr 0x2000, mem_wmask 0b1100, mem_wdata 0xBEEF0000, mem_write high 3 cycles, rsp_rdata 0.
- lw at 0x1001 → err 01 one cycle after accept, mem_read never high. funct3 011 at XLEN=32 → err 10.
- TIMEOUT=4 with no mem_resp → mem_read high 4 cycles, then err 11, then req_ready=1. Rerun with mem_resp on the 4th ACCESS cycle → err 00.
- XLEN=64, mem_rdata=0x80000001_00000000 at address 0x4:
  - lwu → 0x00000000_80000001.
  - lw → 0xFFFFFFFF_80000001.
  - sd at 0x8 → wmask 0xFF, mem_addr 0x8.
- Assert rst in the 2nd ACCESS cycle of a load, with mem_resp given afterwards → strobes 0 next cycle, no rsp_valid. A new request accepted after rst falls completes normally.
